// File: rtl/cmp_share_arbiter.sv
// Round-robin front end that time-shares one 32-bit unsigned magnitude comparator
// among NREQ requesters, one transaction in flight, with valid/ready request and response.

module comparator_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        lt_o,
  output logic        eq_o,
  output logic        gt_o
);

  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i > b_i);

endmodule

module cmp_share_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [32*NREQ-1:0]     req_a_i,
  input  logic [32*NREQ-1:0]     req_b_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [$clog2(NREQ)-1:0] rsp_id_o,
  output logic                   rsp_lt_o,
  output logic                   rsp_eq_o,
  output logic                   rsp_gt_o,
  output logic [31:0]            rsp_result_o,
  output logic                   busy_o
);

  localparam int IDW    = $clog2(NREQ);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      last_q, last_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic                rsp_lt_q, rsp_lt_d;
  logic                rsp_eq_q, rsp_eq_d;
  logic                rsp_gt_q, rsp_gt_d;

  logic                any_valid;
  logic [IDW-1:0]      grant_idx;
  logic [IDW-1:0]      cand;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic [NREQ-1:0]     req_ready;
  logic                cmp_lt, cmp_eq, cmp_gt;

  // Search starts one past the last grantee so every requester is reached within NREQ grants.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_q) + i) % NREQ);
      if (!any_valid && req_valid_i[cand]) begin
        any_valid = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        sel_a = req_a_i[32*k +: 32];
        sel_b = req_b_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && any_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  comparator_32bit u_cmp (
    .a_i  (op_a_q),
    .b_i  (op_b_q),
    .lt_o (cmp_lt),
    .eq_o (cmp_eq),
    .gt_o (cmp_gt)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_lt_d    = rsp_lt_q;
    rsp_eq_d    = rsp_eq_q;
    rsp_gt_d    = rsp_gt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          id_d    = grant_idx;
          last_d  = grant_idx;
          state_d = CMP;
        end
      end
      CMP: begin
        rsp_lt_d    = cmp_lt;
        rsp_eq_d    = cmp_eq;
        rsp_gt_d    = cmp_gt;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // Response fields are left as-is after the handshake; only valid drops.
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_lt_q    <= 1'b0;
      rsp_eq_q    <= 1'b0;
      rsp_gt_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_lt_q    <= rsp_lt_d;
      rsp_eq_q    <= rsp_eq_d;
      rsp_gt_q    <= rsp_gt_d;
    end
  end

  assign req_ready_o  = req_ready;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_lt_o     = rsp_lt_q;
  assign rsp_eq_o     = rsp_eq_q;
  assign rsp_gt_o     = rsp_gt_q;
  assign rsp_result_o = {30'd0, rsp_gt_q, rsp_lt_q};
  assign busy_o       = (state_q != IDLE);

endmodule
